// File: rtl/ip_rcv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ip_rcv_pkg
// Brief    : Shared types and constants for the IPv4 receive path.
// Revision : 1.0
// ============================================================================
package ip_rcv_pkg;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_OPT   = 3'd1,
    ST_PAY   = 3'd2,
    ST_DROP  = 3'd3,
    ST_FLUSH = 3'd4
  } rcv_state_e;

  localparam logic [7:0]  IP_PROTO_UDP     = 8'd17;
  localparam int          IP_HDR_MIN_BYTES = 20;
  localparam logic [31:0] IP_BCAST_ADDR    = 32'hFFFF_FFFF;

  // Ones'-complement 16-bit add with end-around carry; one fold is enough.
  function automatic logic [15:0] csum_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ip_rcv_if.sv
`default_nettype none
// ============================================================================
// Module   : ip_rcv_if
// Brief    : Byte-wide AXI-Stream style link (data/valid/last/ready).
// Revision : 1.0
// ============================================================================
interface ip_rcv_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input  tready);
  modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/ip_csum_acc.sv
`default_nettype none
// ============================================================================
// Module   : ip_csum_acc
// Brief    : Byte-serial 16-bit ones'-complement accumulator (big-endian words).
// Revision : 1.0
// ============================================================================
module ip_csum_acc
  import ip_rcv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] sum_o
);

  logic [15:0] sum_q;
  logic [7:0]  hi_q;
  logic        lo_q;
  logic [15:0] base;
  logic        lo_now;

  // clr_i together with en_i means byte_i is the first (high) byte of a new sum.
  assign base   = clr_i ? 16'd0 : sum_q;
  assign lo_now = lo_q && !clr_i;
  assign sum_o  = (en_i && lo_now) ? csum_add(base, {hi_q, byte_i}) : base;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= 16'd0;
      hi_q  <= 8'd0;
      lo_q  <= 1'b0;
    end else if (en_i) begin
      if (lo_now) begin
        sum_q <= sum_o;
        lo_q  <= 1'b0;
      end else begin
        sum_q <= base;
        hi_q  <= byte_i;
        lo_q  <= 1'b1;
      end
    end else if (clr_i) begin
      sum_q <= 16'd0;
      lo_q  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ip_rcv.sv
`default_nettype none
// ============================================================================
// Module   : ip_rcv
// Brief    : IPv4 receive filter; forwards accepted UDP segments byte-by-byte.
// Revision : 1.0
// ============================================================================
module ip_rcv
  import ip_rcv_pkg::*;
#(
  parameter logic [31:0] LOCAL_IP     = 32'hC0A8_010A,
  parameter bit          ACCEPT_BCAST = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  ip_rcv_if.slave       ip_axis,
  ip_rcv_if.master      udp_axis,
  output logic [31:0]   src_ip_out,
  output logic [15:0]   drop_cnt_out,
  output logic          err_trunc_out
);

  localparam logic [7:0] HDR_LAST_IDX = 8'(IP_HDR_MIN_BYTES - 1);

  rcv_state_e  state_q;
  logic [7:0]  cnt_q;
  logic [7:0]  ver_ihl_q;
  logic [7:0]  proto_q;
  logic [15:0] tot_len_q;
  logic [15:0] rem_q;
  logic [15:0] drop_cnt_q;
  logic [31:0] src_q;
  logic [31:0] dst_q;
  logic [31:0] src_ip_q;
  logic        err_trunc_q;

  logic        in_fire;
  logic        hdr_phase;
  logic        hdr_last;
  logic        dst_ok;
  logic        accept;
  logic [3:0]  ihl;
  logic [7:0]  hdr_bytes;
  logic [15:0] pay_len;
  logic [15:0] csum;
  logic [15:0] drop_cnt_d;
  logic [31:0] dst_full;

  assign ihl       = ver_ihl_q[3:0];
  assign hdr_bytes = {2'b00, ihl, 2'b00};
  assign hdr_phase = (state_q == ST_HDR) || (state_q == ST_OPT);
  assign in_fire   = ip_axis.tvalid && ip_axis.tready;

  assign ip_axis.tready  = (state_q == ST_PAY) ? udp_axis.tready : 1'b1;
  assign udp_axis.tvalid = (state_q == ST_PAY) && ip_axis.tvalid;
  assign udp_axis.tdata  = ip_axis.tdata;
  assign udp_axis.tlast  = (state_q == ST_PAY) && ((rem_q == 16'd1) || ip_axis.tlast);

  // IHL below 5 is still judged at byte 19 so a bad header cannot stall parsing.
  assign hdr_last = ((state_q == ST_HDR) && (cnt_q == HDR_LAST_IDX) && (ihl <= 4'd5)) ||
                    ((state_q == ST_OPT) && (cnt_q == hdr_bytes - 8'd1));

  assign dst_full   = (state_q == ST_HDR) ? {dst_q[23:0], ip_axis.tdata} : dst_q;
  assign dst_ok     = (dst_full == LOCAL_IP) || (ACCEPT_BCAST && (dst_full == IP_BCAST_ADDR));
  assign pay_len    = tot_len_q - {8'd0, hdr_bytes};
  assign drop_cnt_d = drop_cnt_q + {15'd0, (drop_cnt_q != 16'hFFFF)};

  assign accept = (ver_ihl_q[7:4] == 4'd4) && (ihl >= 4'd5) &&
                  (tot_len_q >= {8'd0, hdr_bytes}) && (proto_q == IP_PROTO_UDP) &&
                  dst_ok && (csum == 16'hFFFF);

  ip_csum_acc u_csum (
    .clk    (clk),
    .reset  (reset),
    .clr_i  ((state_q == ST_HDR) && (cnt_q == 8'd0)),
    .en_i   (in_fire && hdr_phase),
    .byte_i (ip_axis.tdata),
    .sum_o  (csum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_HDR;
      cnt_q       <= 8'd0;
      ver_ihl_q   <= 8'd0;
      proto_q     <= 8'd0;
      tot_len_q   <= 16'd0;
      rem_q       <= 16'd0;
      drop_cnt_q  <= 16'd0;
      src_q       <= 32'd0;
      dst_q       <= 32'd0;
      src_ip_q    <= 32'd0;
      err_trunc_q <= 1'b0;
    end else begin
      err_trunc_q <= 1'b0;
      if (in_fire) begin
        case (state_q)
          ST_HDR, ST_OPT: begin
            if (cnt_q == 8'd0) ver_ihl_q <= ip_axis.tdata;
            if (cnt_q == 8'd2) tot_len_q[15:8] <= ip_axis.tdata;
            if (cnt_q == 8'd3) tot_len_q[7:0]  <= ip_axis.tdata;
            if (cnt_q == 8'd9) proto_q <= ip_axis.tdata;
            if ((cnt_q >= 8'd12) && (cnt_q <= 8'd15)) src_q <= {src_q[23:0], ip_axis.tdata};
            if ((cnt_q >= 8'd16) && (cnt_q <= 8'd19)) dst_q <= {dst_q[23:0], ip_axis.tdata};
            cnt_q <= cnt_q + 8'd1;
            if (hdr_last) begin
              cnt_q <= 8'd0;
              if (accept) begin
                src_ip_q <= src_q;
                rem_q    <= pay_len;
                if (ip_axis.tlast) begin
                  state_q     <= ST_HDR;
                  err_trunc_q <= (pay_len != 16'd0);
                end else if (pay_len == 16'd0) begin
                  state_q <= ST_FLUSH;
                end else begin
                  state_q <= ST_PAY;
                end
              end else begin
                drop_cnt_q <= drop_cnt_d;
                state_q    <= ip_axis.tlast ? ST_HDR : ST_DROP;
              end
            end else if (ip_axis.tlast) begin
              cnt_q      <= 8'd0;
              drop_cnt_q <= drop_cnt_d;
              state_q    <= ST_HDR;
            end else if (cnt_q == HDR_LAST_IDX) begin
              state_q <= ST_OPT;
            end
          end
          ST_PAY: begin
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_q <= ip_axis.tlast ? ST_HDR : ST_FLUSH;
            end else if (ip_axis.tlast) begin
              err_trunc_q <= 1'b1;
              state_q     <= ST_HDR;
            end
          end
          ST_DROP, ST_FLUSH: begin
            if (ip_axis.tlast) state_q <= ST_HDR;
          end
          default: state_q <= ST_HDR;
        endcase
      end
    end
  end

  assign src_ip_out    = src_ip_q;
  assign drop_cnt_out  = drop_cnt_q;
  assign err_trunc_out = err_trunc_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_rcv.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_rcv
// Brief    : Self-checking bench for ip_rcv with a packet-level reference model.
// Revision : 1.0
// ============================================================================
module tb_ip_rcv;

  localparam logic [31:0] LOCAL_IP = 32'hC0A8_010A;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ip_rcv_if in_if ();
  ip_rcv_if out_if ();
  logic [31:0] src_ip_out;
  logic [15:0] drop_cnt_out;
  logic        err_trunc_out;

  ip_rcv #(.LOCAL_IP(LOCAL_IP), .ACCEPT_BCAST(1'b1)) dut (
    .clk           (clk),
    .reset         (reset),
    .ip_axis       (in_if),
    .udp_axis      (out_if),
    .src_ip_out    (src_ip_out),
    .drop_cnt_out  (drop_cnt_out),
    .err_trunc_out (err_trunc_out)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_data[$];
  bit          exp_last[$];
  logic [7:0]  pkt[$];
  int          exp_drop = 0;
  logic [31:0] exp_src = 32'd0;
  int          exp_err = 0;
  int          err_seen = 0;
  int          out_cnt = 0;
  bit          stall_en = 0;
  bit          gap_en = 0;
  bit          rand_id = 0;
  bit          abort = 0;
  logic [7:0]  mon_d;
  bit          mon_l;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Ones'-complement sum over the first n bytes, folded only at the end.
  function automatic logic [15:0] ocsum(input logic [7:0] b[$], input int n);
    int unsigned s = 0;
    for (int i = 0; i < n; i += 2) s += {b[i], b[i+1]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    return s[15:0];
  endfunction

  task automatic gen_pkt(input logic [3:0] ver, input int ihl, input int pay, input int pad,
                         input logic [7:0] proto, input logic [31:0] dst, input logic [31:0] src,
                         input bit bad_ck, input int tl_adj, input int cut);
    logic [15:0] tot;
    logic [15:0] ck;
    pkt.delete();
    tot = 16'(ihl * 4 + pay + tl_adj);
    pkt.push_back({ver, 4'(ihl)});
    pkt.push_back(8'h00);
    pkt.push_back(tot[15:8]);
    pkt.push_back(tot[7:0]);
    pkt.push_back(rand_id ? 8'($urandom) : 8'h00);
    pkt.push_back(rand_id ? 8'($urandom) : 8'h00);
    pkt.push_back(8'h40);
    pkt.push_back(8'h00);
    pkt.push_back(8'd64);
    pkt.push_back(proto);
    pkt.push_back(8'h00);
    pkt.push_back(8'h00);
    for (int i = 3; i >= 0; i--) pkt.push_back(8'(src >> (8 * i)));
    for (int i = 3; i >= 0; i--) pkt.push_back(8'(dst >> (8 * i)));
    for (int i = 0; i < ihl * 4 - 20 + pay + pad; i++) pkt.push_back(8'($urandom));
    ck = ~ocsum(pkt, ihl * 4);
    pkt[10] = ck[15:8];
    pkt[11] = ck[7:0];
    if (bad_ck) pkt[10] = ~pkt[10];
    if (cut > 0) while (pkt.size() > cut) void'(pkt.pop_back());
  endtask

  // Derives the expected outcome of the packet currently in pkt from its bytes alone.
  task automatic model_pkt();
    int n, ihl, hb, tl, pl, avail, fwd;
    logic [7:0] b0;
    logic [31:0] dst, src;
    bit ok;
    n   = pkt.size();
    b0  = pkt[0];
    ihl = int'(b0[3:0]);
    hb  = (ihl > 5) ? ihl * 4 : 20;
    if (n < hb) begin
      exp_drop++;
      return;
    end
    tl  = int'({pkt[2], pkt[3]});
    dst = {pkt[16], pkt[17], pkt[18], pkt[19]};
    src = {pkt[12], pkt[13], pkt[14], pkt[15]};
    ok  = (b0[7:4] == 4'd4) && (ihl >= 5) && (tl >= ihl * 4) && (pkt[9] == 8'd17) &&
          ((dst == LOCAL_IP) || (dst == 32'hFFFF_FFFF)) && (ocsum(pkt, hb) == 16'hFFFF);
    if (!ok) begin
      exp_drop++;
      return;
    end
    exp_src = src;
    pl    = tl - hb;
    avail = n - hb;
    fwd   = (pl < avail) ? pl : avail;
    for (int i = 0; i < fwd; i++) begin
      exp_data.push_back(pkt[hb + i]);
      exp_last.push_back(i == fwd - 1);
    end
    if (avail < pl) exp_err++;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit last);
    int guard = 0;
    bit done = 0;
    if (abort) return;
    while (!done) begin
      @(negedge clk);
      out_if.tready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (gap_en && ($urandom_range(0, 4) == 0)) begin
        in_if.tvalid = 1'b0;
        in_if.tdata  = 8'($urandom);
        in_if.tlast  = 1'b0;
      end else begin
        in_if.tvalid = 1'b1;
        in_if.tdata  = d;
        in_if.tlast  = last;
      end
      #1;
      if (in_if.tvalid && in_if.tready) done = 1;
      else if (++guard > 500) begin
        checks++;
        failures++;
        $display("FAIL input_timeout actual=stalled required=accepted");
        abort = 1;
        done  = 1;
      end
    end
  endtask

  task automatic send_pkt(input int nbytes);
    for (int i = 0; i < nbytes; i++) send_byte(pkt[i], i == pkt.size() - 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_if.tvalid  = 1'b0;
      in_if.tlast   = 1'b0;
      out_if.tready = 1'b1;
    end
  endtask

  task automatic end_check();
    idle(6);
    check("drop_cnt", 64'(drop_cnt_out), 64'(exp_drop));
    check("src_ip", 64'(src_ip_out), 64'(exp_src));
    check("err_trunc_count", 64'(err_seen), 64'(exp_err));
    check("missing_out_bytes", 64'(exp_data.size()), 64'd0);
    exp_data.delete();
    exp_last.delete();
  endtask

  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (err_trunc_out) err_seen++;
      if (out_if.tvalid) check("tready_track", 64'(in_if.tready), 64'(out_if.tready));
      if (out_if.tvalid && out_if.tready) begin
        out_cnt++;
        if (exp_data.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_byte actual=%0h required=none", out_if.tdata);
        end else begin
          mon_d = exp_data.pop_front();
          mon_l = exp_last.pop_front();
          check("out_data", 64'(out_if.tdata), 64'(mon_d));
          check("out_last", 64'(out_if.tlast), 64'(mon_l));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0, e0, ihl, pay, pad, cut, tl_adj, nb;
    logic [31:0] dst;
    reset         = 1'b1;
    in_if.tvalid  = 1'b1;
    in_if.tdata   = 8'hAA;
    in_if.tlast   = 1'b0;
    out_if.tready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("rst_udp_tvalid", 64'(out_if.tvalid), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt_out), 64'd0);
    check("rst_src_ip", 64'(src_ip_out), 64'd0);
    check("rst_err_trunc", 64'(err_trunc_out), 64'd0);
    @(negedge clk);
    in_if.tvalid = 1'b0;
    reset        = 1'b0;
    idle(2);

    // Basic good packet; the checksum literal pins the model's ones'-complement sum.
    gen_pkt(4'd4, 5, 8, 0, 8'd17, LOCAL_IP, 32'hC0A8_0101, 0, 0, 0);
    check("pin_csum", 64'({pkt[10], pkt[11]}), 64'hB775);
    model_pkt();
    o0 = out_cnt;
    send_pkt(pkt.size());
    end_check();
    check("good_out_count", 64'(out_cnt - o0), 64'd8);
    check("good_drop_lit", 64'(drop_cnt_out), 64'd0);
    check("good_src_lit", 64'(src_ip_out), 64'hC0A8_0101);

    // Corrupted checksum, then a good packet.
    gen_pkt(4'd4, 5, 8, 0, 8'd17, LOCAL_IP, 32'h0A0B_0C0D, 1, 0, 0);
    model_pkt();
    o0 = out_cnt;
    send_pkt(pkt.size());
    end_check();
    check("badck_out_count", 64'(out_cnt - o0), 64'd0);
    check("badck_drop_lit", 64'(drop_cnt_out), 64'd1);
    check("badck_src_held", 64'(src_ip_out), 64'hC0A8_0101);
    gen_pkt(4'd4, 5, 8, 0, 8'd17, LOCAL_IP, 32'hC0A8_0102, 0, 0, 0);
    model_pkt();
    o0 = out_cnt;
    send_pkt(pkt.size());
    end_check();
    check("after_bad_out_count", 64'(out_cnt - o0), 64'd8);

    // Reset in the middle of a header, then a clean packet must parse from byte 0.
    gen_pkt(4'd4, 5, 8, 0, 8'd17, LOCAL_IP, 32'h0101_0101, 0, 0, 0);
    send_pkt(9);
    @(negedge clk);
    in_if.tvalid = 1'b0;
    reset        = 1'b1;
    idle(2);
    @(negedge clk);
    reset    = 1'b0;
    exp_drop = 0;
    exp_src  = 32'd0;
    exp_err  = 0;
    err_seen = 0;
    exp_data.delete();
    exp_last.delete();
    #2;
    check("midrst_drop", 64'(drop_cnt_out), 64'd0);
    check("midrst_src", 64'(src_ip_out), 64'd0);
    gen_pkt(4'd4, 5, 8, 0, 8'd17, LOCAL_IP, 32'hC0A8_0103, 0, 0, 0);
    model_pkt();
    o0 = out_cnt;
    send_pkt(pkt.size());
    end_check();
    check("midrst_out_count", 64'(out_cnt - o0), 64'd8);

    // TCP packet, then a foreign destination.
    gen_pkt(4'd4, 5, 8, 0, 8'd6, LOCAL_IP, 32'h0202_0202, 0, 0, 0);
    model_pkt();
    send_pkt(pkt.size());
    gen_pkt(4'd4, 5, 8, 0, 8'd17, 32'h0A00_0001, 32'h0303_0303, 0, 0, 0);
    model_pkt();
    send_pkt(pkt.size());
    end_check();
    check("tcp_foreign_drop_lit", 64'(drop_cnt_out), 64'd2);

    // IHL 6 with options; options never reach the output.
    gen_pkt(4'd4, 6, 8, 0, 8'd17, LOCAL_IP, 32'h0404_0404, 0, 0, 0);
    model_pkt();
    o0 = out_cnt;
    send_pkt(pkt.size());
    end_check();
    check("opt_out_count", 64'(out_cnt - o0), 64'd8);

    // Ethernet padding to 46 bytes, followed back-to-back by a good packet.
    gen_pkt(4'd4, 5, 10, 16, 8'd17, LOCAL_IP, 32'h0505_0505, 0, 0, 0);
    check("pad_len", 64'(pkt.size()), 64'd46);
    model_pkt();
    o0 = out_cnt;
    send_pkt(pkt.size());
    gen_pkt(4'd4, 5, 8, 0, 8'd17, LOCAL_IP, 32'h0606_0606, 0, 0, 0);
    model_pkt();
    send_pkt(pkt.size());
    end_check();
    check("pad_out_count", 64'(out_cnt - o0), 64'd18);

    // Downstream stalls, then truncation at payload byte 4 of 8.
    stall_en = 1;
    gap_en   = 1;
    gen_pkt(4'd4, 5, 8, 0, 8'd17, LOCAL_IP, 32'h0707_0707, 0, 0, 0);
    model_pkt();
    o0 = out_cnt;
    send_pkt(pkt.size());
    end_check();
    check("stall_out_count", 64'(out_cnt - o0), 64'd8);
    gen_pkt(4'd4, 5, 8, 0, 8'd17, LOCAL_IP, 32'h0808_0808, 0, 0, 24);
    model_pkt();
    o0 = out_cnt;
    e0 = err_seen;
    send_pkt(pkt.size());
    end_check();
    check("trunc_out_count", 64'(out_cnt - o0), 64'd4);
    check("trunc_err_pulses", 64'(err_seen - e0), 64'd1);

    // Randomized bursts of back-to-back packets.
    rand_id = 1;
    for (int it = 0; it < 80 && !abort; it++) begin
      stall_en = $urandom_range(0, 1) != 0;
      gap_en   = $urandom_range(0, 1) != 0;
      nb       = $urandom_range(1, 3);
      for (int p = 0; p < nb; p++) begin
        ihl    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 8)) : 5;
        pay    = $urandom_range(0, 16);
        tl_adj = 0;
        if ($urandom_range(0, 15) == 0) begin
          pay    = 0;
          tl_adj = -4;
        end
        pad = 0;
        if ((ihl * 4 + pay < 46) && ($urandom_range(0, 2) == 0)) pad = 46 - (ihl * 4 + pay);
        case ($urandom_range(0, 9))
          0:       dst = 32'h0A00_0000 | 32'($urandom_range(0, 65535));
          1:       dst = 32'hFFFF_FFFF;
          default: dst = LOCAL_IP;
        endcase
        cut = 0;
        case ($urandom_range(0, 9))
          0: cut = $urandom_range(1, ihl * 4 - 1);
          1: if (pay >= 2) cut = ihl * 4 + int'($urandom_range(1, pay - 1));
          default: cut = 0;
        endcase
        gen_pkt(($urandom_range(0, 15) == 0) ? 4'd6 : 4'd4, ihl, pay, pad,
                ($urandom_range(0, 7) == 0) ? 8'd6 : 8'd17, dst, $urandom,
                $urandom_range(0, 7) == 0, tl_adj, cut);
        model_pkt();
        send_pkt(pkt.size());
      end
      end_check();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
